wasca_ociram_sp_ram_gen: RTL

//  Parametrised single-port on-chip RAM for the Nios II OCI debug/monitor path.

---
 rtl/wasca_ociram_pkg.sv | 17 +
 rtl/wasca_ociram_sp_ram_gen_if.sv | 39 +++
 rtl/wasca_ociram_bram_core.sv | 47 ++++
 rtl/wasca_ociram_sp_ram_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/wasca_ociram_pkg.sv
// Shared types and helpers for the OCI debug RAM: clear/run state encoding,
// byte lane width and the even-parity helper used when parity storage is built.
package wasca_ociram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  // Parity bit that makes {parity, byte} an even-parity lane.
  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/wasca_ociram_sp_ram_gen_if.sv
// Access bus of the OCI debug RAM: request side driven by the register decode,
// response side driven by the RAM. parity_err only exists when OCIRAM_PARITY_EN
// is defined.
interface wasca_ociram_sp_ram_gen_if
  import wasca_ociram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                         reset_req;
  logic [ADDR_WIDTH-1:0]        address;
  logic [DATA_WIDTH/BYTE_W-1:0] byteenable;
  logic [DATA_WIDTH-1:0]        data;
  logic                         wren;
  logic                         rden;
  logic [DATA_WIDTH-1:0]        q;
  logic                         q_valid;
  logic                         init_busy;
`ifdef OCIRAM_PARITY_EN
  logic                         parity_err;
`endif

  modport master (
    output reset_req, address, byteenable, data, wren, rden,
`ifdef OCIRAM_PARITY_EN
    input  parity_err,
`endif
    input  q, q_valid, init_busy
  );

  modport slave (
    input  reset_req, address, byteenable, data, wren, rden,
`ifdef OCIRAM_PARITY_EN
    output parity_err,
`endif
    output q, q_valid, init_busy
  );

endinterface

// File: rtl/wasca_ociram_bram_core.sv
// Inferred single-port block RAM with per-lane write enables and a registered
// read. Reads return the contents before a same-cycle write. ce=0 freezes
// both the array and the read register.
module wasca_ociram_bram_core #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_W     = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ce,
  input  logic                              we,
  input  logic                              re,
  input  logic [NUM_LANES-1:0]              be,
  input  logic [ADDR_WIDTH-1:0]             addr,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]  wdata,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  rdata
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH];
  logic [NUM_LANES-1:0][LANE_W-1:0] rdata_q, rdata_d;

  // Lane-granular write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ce && we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem[addr][i] <= wdata[i];
      end
    end
  end

  // Read register loads only on an accepted read so it holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (ce && re) rdata_d = mem[addr];
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wasca_ociram_sp_ram_gen.sv
// OCI debug/monitor RAM: after reset a sequencer fills every word with
// INIT_VALUE (init_busy high), then byte-lane reads/writes are served with
// latency 1 (OUT_REG=0) or 2 (OUT_REG=1). reset_req freezes the array and the
// read pipeline. Optional macro OCIRAM_PARITY_EN adds one even-parity bit per
// stored byte and a parity_err strobe aligned with q_valid.
module wasca_ociram_sp_ram_gen
  import wasca_ociram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  wasca_ociram_sp_ram_gen_if.slave bus
);
  localparam int NUM_LANES = DATA_WIDTH / BYTE_W;
`ifdef OCIRAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int LANE_W = BYTE_W + PAR_W;
  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  state_e                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            cnt_q, cnt_d;
  logic                             clearing, ce, rd_acc, wr_en;
  logic [NUM_LANES-1:0]             wr_be;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic [NUM_LANES-1:0][LANE_W-1:0] wr_word, rd_word, out_word;
  logic [STAGES:1]                  vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]                  vld_pipe;

  assign clearing = (state_q == S_CLEAR);
  assign ce       = ~bus.reset_req;

  // Clear sequencer: one word per unfrozen cycle, exit after the last address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CLEAR: begin
        if (ce) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_RUN;
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_CLEAR;
    endcase
  end

  // State and clear counter; reset restarts the clear from address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array port mux: the sequencer owns the port while clearing, so user
  // accesses in that window are simply dropped.
  always_comb begin
    mem_addr = clearing ? cnt_q : bus.address;
    wr_data  = clearing ? INIT_VALUE : bus.data;
    wr_be    = clearing ? '1 : bus.byteenable;
    wr_en    = ~reset & (clearing | bus.wren);
    rd_acc   = ~clearing & ce & bus.rden;
  end

  // Pack each write byte into a stored lane, with its parity bit when built.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
`ifdef OCIRAM_PARITY_EN
      wr_word[i] = {even_parity(wr_data[i*BYTE_W +: BYTE_W]), wr_data[i*BYTE_W +: BYTE_W]};
`else
      wr_word[i] = wr_data[i*BYTE_W +: BYTE_W];
`endif
    end
  end

  wasca_ociram_bram_core #(
    .NUM_LANES  (NUM_LANES),
    .LANE_W     (LANE_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk   (clock),
    .rst   (reset),
    .ce    (ce),
    .we    (wr_en),
    .re    (rd_acc),
    .be    (wr_be),
    .addr  (mem_addr),
    .wdata (wr_word),
    .rdata (rd_word)
  );

  // Read-valid shift register; bit 0 is the read accepted this cycle.
  assign vld_pipe = {vld_pipe_q, rd_acc};

  // Advance the valid pipe only when not frozen.
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (ce) vld_pipe_d = vld_pipe[STAGES-1:0];
  end

  // Valid pipe register, flushed by reset.
  always_ff @(posedge clock) begin
    if (reset) vld_pipe_q <= '0;
    else       vld_pipe_q <= vld_pipe_d;
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [NUM_LANES-1:0][LANE_W-1:0] q_word_q, q_word_d;

      // Capture the array output only when a read moves into the last stage.
      always_comb begin
        q_word_d = q_word_q;
        if (ce && vld_pipe[1]) q_word_d = rd_word;
      end

      // Extra output register.
      always_ff @(posedge clock) begin
        if (reset) q_word_q <= '0;
        else       q_word_q <= q_word_d;
      end

      assign out_word = q_word_q;
    end else begin : g_no_out_reg
      assign out_word = rd_word;
    end
  endgenerate

  // Strip stored lanes back to the data word.
  always_comb begin
    bus.q = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      bus.q[i*BYTE_W +: BYTE_W] = out_word[i][BYTE_W-1:0];
    end
  end

  assign bus.q_valid   = vld_pipe[STAGES];
  assign bus.init_busy = clearing;

`ifdef OCIRAM_PARITY_EN
  logic par_bad;

  // Any lane with odd overall parity flags the returned word.
  always_comb begin
    par_bad = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) par_bad = par_bad | (^out_word[i]);
    bus.parity_err = vld_pipe[STAGES] & par_bad;
  end
`endif

endmodule
